// File: rtl/fp_seq_divider_if.sv
// Request/result bundle for fp_seq_divider: operands in, quotient and status flags out.
interface fp_seq_divider_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] final_val;
  logic [3:0]   flags;

  modport master (output start, in1, in2, input busy, done, final_val, flags);
  modport slave  (input start, in1, in2, output busy, done, final_val, flags);
endinterface

// File: rtl/fp_seq_divider.sv
// Sequential IEEE-754 style divider: restoring shift-subtract, flush-to-zero, fixed latency.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_seq_divider #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  fp_seq_divider_if.slave  bus
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned Q_W   = MAN_W + 3;
  localparam int unsigned R_W   = MAN_W + 3;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned CNT_W = $clog2(Q_W + 1);
  localparam logic signed [E_W-1:0] BIAS = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EMAX = E_W'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, PACK} state_t;

  state_t                  state;
  logic [W-1:0]            a_q, b_q;
  logic                    sign_q;
  logic                    special_q;
  logic [W-1:0]            special_res_q;
  logic [3:0]              special_flags_q;
  logic [R_W-1:0]          rem;
  logic [SIG_W-1:0]        div;
  logic [Q_W-1:0]          quo;
  logic [CNT_W-1:0]        cnt;
  logic signed [E_W-1:0]   exp_q;
  logic [MAN_W-1:0]        mant_q;

  // Operand classification and special-case result
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             special;
  logic [W-1:0]     special_res;
  logic [3:0]       special_flags;

  always_comb begin
    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sgn    = a_q[W-1] ^ b_q[W-1];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    special       = 1'b1;
    special_res   = {sgn, {(W-1){1'b0}}};
    special_flags = 4'b0000;
    if (a_nan || b_nan) begin
      special_res = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res   = QNAN;
      special_flags = 4'b1000;
    end else if (a_inf) begin
      special_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      special_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      special_flags = 4'b0100;
    end else if (b_inf || a_zero) begin
      special_res = {sgn, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise the quotient by at most one place, then round
  logic               msb, guard, sticky, round_up, carry;
  logic [SIG_W-1:0]   mant_pre;
  logic [SIG_W:0]     mant_sum;
  logic signed [E_W-1:0] exp_n;
  logic [MAN_W-1:0]   mant_n;

  always_comb begin
    msb      = quo[Q_W-1];
    mant_pre = msb ? quo[Q_W-1:2] : quo[Q_W-2:1];
    guard    = msb ? quo[1] : quo[0];
    sticky   = (msb & quo[0]) | (rem != '0);
    round_up = RNE & guard & (sticky | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + (SIG_W+1)'(round_up);
    carry    = mant_sum[SIG_W];
    mant_n   = carry ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];
    exp_n    = exp_q - E_W'(!msb) + E_W'(carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.final_val   <= '0;
      bus.flags       <= '0;
      a_q             <= '0;
      b_q             <= '0;
      sign_q          <= 1'b0;
      special_q       <= 1'b0;
      special_res_q   <= '0;
      special_flags_q <= '0;
      rem             <= '0;
      div             <= '0;
      quo             <= '0;
      cnt             <= '0;
      exp_q           <= '0;
      mant_q          <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.in1;
            b_q      <= bus.in2;
            bus.busy <= 1'b1;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q          <= sgn;
          special_q       <= special;
          special_res_q   <= special_res;
          special_flags_q <= special_flags;
          rem             <= R_W'({1'b1, fa});
          div             <= {1'b1, fb};
          quo             <= '0;
          cnt             <= '0;
          exp_q           <= E_W'(ea) - E_W'(eb) + BIAS;
          state           <= DIVIDE;
        end
        DIVIDE: begin
          if (rem >= R_W'(div)) begin
            rem <= (rem - R_W'(div)) << 1;
            quo <= {quo[Q_W-2:0], 1'b1};
          end else begin
            rem <= rem << 1;
            quo <= {quo[Q_W-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Q_W - 1)) state <= NORM;
        end
        NORM: begin
          exp_q  <= exp_n;
          mant_q <= mant_n;
          state  <= PACK;
        end
        PACK: begin
          if (special_q) begin
            bus.final_val <= special_res_q;
            bus.flags     <= special_flags_q;
          end else if (exp_q >= EMAX) begin
            bus.final_val <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            bus.flags     <= 4'b0010;
          end else if (exp_q[E_W-1] || (exp_q == '0)) begin
            bus.final_val <= {sign_q, {(W-1){1'b0}}};
            bus.flags     <= 4'b0001;
          end else begin
            bus.final_val <= {sign_q, exp_q[EXP_W-1:0], mant_q};
            bus.flags     <= 4'b0000;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_seq_divider.sv
// Directed bench for fp_seq_divider; expected results queued at issue and checked on done.
module tb_fp_seq_divider;
  localparam int LAT = 29;
`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  fp_seq_divider_if #(.EXP_W(8), .MAN_W(23)) dut_if ();

  fp_seq_divider #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && dut_if.done === 1'b1) begin
      n_assert++;
      assert (sb.size() !== 0) else begin
        n_fail++;
        $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_result"}, dut_if.final_val, e.res);
        check({e.tag, "_flags"}, 32'(dut_if.flags), 32'(e.flg));
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f, input string tag);
    exp_t e;
    e.res = r; e.flg = f; e.due = cyc + 1 + LAT; e.tag = tag;
    sb.push_back(e);
    dut_if.in1   = a;
    dut_if.in2   = b;
    dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input string tag);
    issue(a, b, r, f, tag);
    wait_empty(tag);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dut_if.start = 1'b0;
    dut_if.in1   = '0;
    dut_if.in2   = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(dut_if.busy), 32'd0);
    check("reset_done", 32'(dut_if.done), 32'd0);
    check("reset_final", dut_if.final_val, 32'd0);
    check("reset_flags", 32'(dut_if.flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, THIRD,        4'b0000, "one_third");
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, "neg_six_by_two");
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, "div_by_zero");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, "zero_by_zero");
    run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, "overflow");
    run_op(32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, "underflow");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, "inf_by_inf");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, "nan_in");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "inf_by_finite");
    run_op(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, "finite_by_inf");
    run_op(32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, "zero_by_finite");
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, "subnormal_ftz");
    run_op(32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, "three_by_two");

    // Back-to-back: second start presented while done is high
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "b2b_first");
    for (int i = 0; i < 60 && dut_if.done !== 1'b1; i++) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "b2b_second");
    wait_empty("b2b");
    @(negedge clk);

    // Start while busy must be ignored
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "busy_ignore");
    repeat (4) @(negedge clk);
    check("busy_high", 32'(dut_if.busy), 32'd1);
    dut_if.in1   = 32'h3F800000;
    dut_if.in2   = 32'h00000000;
    dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
    wait_empty("busy_ignore");
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    issue(32'h3F800000, 32'h40400000, THIRD, 4'b0000, "aborted");
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", 32'(dut_if.busy), 32'd0);
    check("abort_done", 32'(dut_if.done), 32'd0);
    check("abort_final", dut_if.final_val, 32'd0);
    check("abort_flags", 32'(dut_if.flags), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_idle", 32'(dut_if.busy), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_seq_divider.md
FP_SEQ_DIVIDER -- requirements
Module: fp_seq_divider

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port in1  input  W  dividend, IEEE-754 layout {sign, exponent, fraction}.
REQ-007 SHALL have port in2  input  W  divisor, same layout.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port final  output  W  quotient; held stable until next done.
REQ-011 SHALL have port flags  output  4  {invalid, div_by_zero, overflow, underflow}; updated with done, held otherwise.

Function
REQ-012 SHALL capture in1/in2 on the rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored.
REQ-013 SHALL implement FSM IDLE -> UNPACK -> DIVIDE -> NORM -> PACK -> IDLE; PACK asserts done.
REQ-014 SHALL spend exactly MAN_W+3 cycles in DIVIDE, one quotient bit per cycle (restoring shift-subtract on {1,fraction} significands); sticky = final remainder nonzero.
REQ-015 SHALL assert done exactly MAN_W+6 cycles after the accepting edge (29 for defaults), for every operand class including specials.
REQ-016 SHALL accept back-to-back operation: start sampled in the same cycle done is high SHALL be accepted.
REQ-017 SHALL compute sign = in1 sign XOR in2 sign for all non-NaN results.
REQ-018 SHALL compute exponent in EXP_W+2-bit signed arithmetic: E1-E2+BIAS, BIAS=2^(EXP_W-1)-1, minus 1 when quotient MSB is 0 (left-normalise by one).
REQ-019 SHALL treat exponent-field-zero inputs (zero and subnormal) as signed zero (flush-to-zero).
REQ-020 SHALL produce: x/0 (x finite nonzero) -> signed inf, div_by_zero=1; 0/0, inf/inf -> canonical NaN (exp all ones, fraction MSB 1, sign 0), invalid=1; any NaN input -> canonical NaN, invalid=0; inf/finite -> signed inf; finite/inf -> signed zero; 0/finite -> signed zero.
REQ-021 SHALL return signed inf and overflow=1 when final exponent (after rounding carry) >= 2^EXP_W-1.
REQ-022 SHALL return signed zero and underflow=1 when final exponent <= 0 (no subnormal output).
REQ-023 SHALL drive busy=0, done=0 in IDLE.

Reset
REQ-024 SHALL on rst force state IDLE, busy=0, done=0, final=0, flags=0 immediately, independent of clk.
REQ-025 SHALL abort any in-flight division on rst with no done pulse; first start after rst release behaves as from power-up.

Configuration
REQ-026 SHALL, when macro FP_DIV_RNE_EN is defined, round to nearest, ties to even, using guard and sticky; mantissa carry-out SHALL increment exponent.
REQ-027 SHALL, when FP_DIV_RNE_EN is undefined, truncate (round toward zero); latency per REQ-015 unchanged.

Verification
REQ-028 SHALL cover: in1=0x40C00000 (6.0), in2=0x40000000 (2.0) -> final=0x40400000, flags=0, done at cycle 29.
REQ-029 SHALL cover: 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FP_DIV_RNE_EN, 0x3EAAAAAA without.
REQ-030 SHALL cover: 0xC0C00000 / 0x40000000 -> 0xC0400000; 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
REQ-031 SHALL cover: 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1; 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow=1.
REQ-032 SHALL cover: 0x00800000 / 0x4B000000 -> 0x00000000, underflow=1.
REQ-033 SHALL cover: rst pulsed at cycle 10 of an operation -> no done, outputs 0; new start afterward completes correctly; second start during busy ignored.
